shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Command-driven sequencer for a WIDTH-bit universal shift register. Accepts one command per valid/ready handshake: parallel load, shift left, shift right or rotate left by N. Steps the register one operation per clock and pulses done on completion. Sits between a host or bus FSM and the shift-register datapath, which it owns and drives.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 3, width of the shift-count field; max shift count is 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 LOAD, 01 SHL, 10 SHR, 11 ROTL
cmd_cnt  in  CNT_W  shift count; ignored for LOAD
cmd_data  in  WIDTH  parallel load value; ignored for shift ops
ser_in  in  1  serial fill bit for SHL/SHR, sampled on every shift edge
q  out  WIDTH  register contents (parallel out)
ser_out  out  1  registered copy of the last bit shifted or rotated out
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): q=0, ser_out=0, done=0, busy=0, FSM=IDLE, internal op/cnt/data registers=0. cmd_ready=1 once reset deasserts.
- FSM states: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1, busy=0. At edge E0 with cmd_valid=1, latch op/cnt/data and go to EXEC.
- EXEC: cmd_ready=0, busy=1.
  - LOAD: q<=data at E1, then go to DONE.
  - cnt=0 on a shift op: no change to q or ser_out, then go to DONE at E1.
  - Otherwise one shift per edge E1..Ec, decrementing the remaining count; go to DONE at the edge that performs the final shift.
- DONE: done=1, busy=1, cmd_ready=0 for exactly one cycle, then IDLE.
- Latency: LOAD has done high in the cycle after E1, with cmd_ready back at E2. A shift of c>0 has done high after Ec, with cmd_ready back at Ec+1. Throughput is one command per c+2 cycles.
- Shift semantics:
  - SHL: q<={q[W-2:0],ser_in}, ser_out<=q[W-1].
  - SHR: q<={ser_in,q[W-1:1]}, ser_out<=q[0].
  - ROTL: q<={q[W-2:0],q[W-1]}, ser_out<=q[W-1].
- Shift counts >= WIDTH are legal. Every step executes, so ROTL by WIDTH returns the original value.
- cmd_valid while cmd_ready=0 is ignored. No queuing. The host must hold cmd_valid until the handshake.
- Input changes on cmd_data/cmd_cnt after acceptance have no effect.
- Reset mid-EXEC aborts the command immediately and produces no done pulse.

Optional Feature:
SHIFT_ABORT_EN
- With the macro defined, an extra input port abort (1 bit) exists. If abort=1 during EXEC, the next edge performs no shift, leaves q and ser_out unchanged, and goes to DONE, so done pulses normally. abort is ignored in IDLE and DONE.
- Without the macro, the port does not exist and commands always run to completion.

Decomposition:
- Shared package/header: op encodings (OP_LOAD, OP_SHL, OP_SHR, OP_ROTL), FSM state encodings, default WIDTH/CNT_W.
- One sub-module, shift_core: the universal shift-register datapath. It has mode input {HOLD, LOAD, SHL, SHR, ROTL}, pi, ser_in, q and ser_out, with the same async active-low reset.
- shift_seq_ctrl contains the FSM, command registers and count-down counter, and drives the mode of shift_core.

Test Plan:
- Reset low for 2 cycles, then high -> q=0000, ser_out=0, done=0, cmd_ready=1.
- LOAD cmd_data=1100 -> q=1100 at E1; done high for one cycle; cmd_ready high at E2.
- From q=1100, SHL cnt=2 with ser_in=1 -> q=1001 then 0011; ser_out=1, then 1; done after E2.
- From q=1010, SHR cnt=1 with ser_in=0 -> q=0101, ser_out=0; done follows. Then ROTL cnt=4 on 1001 -> q=0011, 0110, 1100, 1001; done after E4.
- SHL cnt=0 -> q unchanged, done one cycle after E1. A cmd_valid pulse while busy=1 is never accepted (q unaffected).
- Reset asserted at E2 of a SHR cnt=5 -> q=0 immediately, no done; after release, a new LOAD 0101 is accepted normally. With SHIFT_ABORT_EN: abort at E2 of ROTL cnt=4 on 1001 -> q stops at 0011, done pulses.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift_seq_ctrl sequencer: command ops, FSM states,
// datapath modes and default sizes.
package shift_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4
    } mode_e;

    function automatic mode_e op_to_mode(input op_e op);
        case (op)
            OP_SHL:  return MODE_SHL;
            OP_SHR:  return MODE_SHR;
            OP_ROTL: return MODE_ROTL;
            default: return MODE_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_shift_core.sv
// Universal shift-register datapath: hold, parallel load, shift left/right
// with serial fill, rotate left. ser_out keeps the last bit pushed out.
module shift_core
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] pi,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out
);

    logic [WIDTH-1:0] r_q;
    logic             r_ser_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            r_ser_out <= 1'b0;
        end else begin
            case (mode)
                MODE_LOAD: r_q <= pi;
                MODE_SHL: begin
                    r_q       <= {r_q[WIDTH-2:0], ser_in};
                    r_ser_out <= r_q[WIDTH-1];
                end
                MODE_SHR: begin
                    r_q       <= {ser_in, r_q[WIDTH-1:1]};
                    r_ser_out <= r_q[0];
                end
                MODE_ROTL: begin
                    r_q       <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    r_ser_out <= r_q[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    assign q       = r_q;
    assign ser_out = r_ser_out;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for shift_core: one command per handshake, one shift per clock.
// Optional SHIFT_ABORT_EN adds an abort input that ends an executing command early.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
`ifdef SHIFT_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is 1 only in IDLE, so valid is ignored otherwise.
    state_e           r_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;

    state_e           w_next_state;
    mode_e            w_mode;
    logic             w_shift;
    logic             w_abort;

`ifdef SHIFT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_shift = (w_mode == MODE_SHL) || (w_mode == MODE_SHR) || (w_mode == MODE_ROTL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && cmd_valid) begin
                r_op   <= op_e'(cmd_op);
                r_cnt  <= cmd_cnt;
                r_data <= cmd_data;
            end else if (w_shift) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mode       = MODE_HOLD;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (w_abort) begin
                    w_next_state = ST_DONE;
                end else if (r_op == OP_LOAD) begin
                    w_mode       = MODE_LOAD;
                    w_next_state = ST_DONE;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end else begin
                    // The edge carrying the last shift also moves to DONE.
                    w_mode = op_to_mode(r_op);
                    if (r_cnt == CNT_W'(1)) w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    shift_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .mode    (w_mode),
        .pi      (r_data),
        .ser_in  (ser_in),
        .q       (q),
        .ser_out (ser_out)
    );

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: reset check, vector table, hand sequences for
// trajectory/busy/reset/abort corners, then random commands against a bit-stream model.
module tb_shift_seq_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 3;
    localparam logic [1:0] T_LOAD = 2'b00;
    localparam logic [1:0] T_SHL  = 2'b01;
    localparam logic [1:0] T_SHR  = 2'b10;
    localparam logic [1:0] T_ROTL = 2'b11;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [W-1:0]     cmd_data;
    logic             ser_in;
    logic [W-1:0]     q;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic [1:0]       o_dbg_state;
`ifdef SHIFT_ABORT_EN
    logic             abort;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] m_q;
    logic         m_ser;
    logic         sbits[0:63];
    logic [W-1:0] traj[0:63];

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cnt     (cmd_cnt),
        .cmd_data    (cmd_data),
        .ser_in      (ser_in),
`ifdef SHIFT_ABORT_EN
        .abort       (abort),
`endif
        .q           (q),
        .ser_out     (ser_out),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_sbits(input logic v);
        for (int i = 0; i < 64; i++) sbits[i] = v;
    endtask

    // Bit-stream model: shifting by c is a window slide of c over the register
    // bits followed by the fill bits; for ROTL the fill is the stream itself.
    task automatic model(input logic [1:0] op, input int cnt, input logic [W-1:0] data,
                         output logic [W-1:0] eq, output logic es, output int lat);
        logic st[0:63];
        eq = m_q;
        es = m_ser;
        lat = (op == T_LOAD || cnt == 0) ? 1 : cnt;
        if (op == T_LOAD) begin
            eq = data;
        end else if (cnt > 0) begin
            for (int i = 0; i < W; i++) st[i] = (op == T_SHR) ? m_q[i] : m_q[W-1-i];
            for (int j = 0; j < cnt; j++) st[W+j] = (op == T_ROTL) ? st[j] : sbits[j];
            for (int i = 0; i < W; i++) begin
                if (op == T_SHR) eq[i] = st[cnt+i];
                else             eq[W-1-i] = st[cnt+i];
            end
            es = st[cnt-1];
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [W-1:0] data,
                           input logic [W-1:0] exp_q, input logic exp_ser, input int exp_lat,
                           input bit pulse_busy, input string name);
        int k;
        bit seen;
        @(negedge clk);
        chk({name, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt[CNT_W-1:0];
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = pulse_busy;
        cmd_op    = pulse_busy ? T_LOAD : 2'($urandom_range(0, 3));
        cmd_cnt   = CNT_W'($urandom_range(0, 7));
        cmd_data  = pulse_busy ? ~exp_q : W'($urandom_range(0, 15));
        k = 0;
        seen = 0;
        ser_in = sbits[0];
        while (!seen && k < 40) begin
            chk({name, "_busy"}, {30'd0, busy, cmd_ready}, 32'b10);
            @(negedge clk);
            k++;
            traj[k] = q;
            if (done) begin
                seen = 1;
                cmd_valid = 1'b0;
            end else begin
                ser_in = sbits[k];
            end
        end
        cmd_valid = 1'b0;
        if (!seen) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(k), 32'(exp_lat));
            chk({name, "_q"}, 32'(q), 32'(exp_q));
            chk({name, "_ser_out"}, 32'(ser_out), 32'(exp_ser));
            chk({name, "_done_busy"}, {30'd0, busy, cmd_ready}, 32'b10);
        end
        @(negedge clk);
        chk({name, "_post"}, {29'd0, done, busy, cmd_ready}, 32'b001);
        chk({name, "_post_q"}, 32'(q), 32'(exp_q));
        m_q   = exp_q;
        m_ser = exp_ser;
    endtask

    typedef struct {
        logic [1:0]   op;
        int           cnt;
        logic [W-1:0] data;
        logic         fill;
        logic [W-1:0] exp_q;
        logic         exp_ser;
        int           exp_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [W-1:0] eq;
        logic         es;
        int           lat;
        logic [1:0]   rop;
        int           rcnt;
        logic [W-1:0] rdata;

        vecs[0]  = '{T_LOAD, 0, 4'b1100, 1'b0, 4'b1100, 1'b0, 1};
        vecs[1]  = '{T_SHL,  2, 4'b1111, 1'b1, 4'b0011, 1'b1, 2};
        vecs[2]  = '{T_LOAD, 0, 4'b1010, 1'b0, 4'b1010, 1'b1, 1};
        vecs[3]  = '{T_SHR,  1, 4'b1111, 1'b0, 4'b0101, 1'b0, 1};
        vecs[4]  = '{T_LOAD, 0, 4'b1001, 1'b0, 4'b1001, 1'b0, 1};
        vecs[5]  = '{T_ROTL, 4, 4'b0000, 1'b0, 4'b1001, 1'b1, 4};
        vecs[6]  = '{T_SHL,  0, 4'b0110, 1'b0, 4'b1001, 1'b1, 1};
        vecs[7]  = '{T_SHR,  7, 4'b0000, 1'b1, 4'b1111, 1'b1, 7};
        vecs[8]  = '{T_ROTL, 5, 4'b0000, 1'b0, 4'b1111, 1'b1, 5};
        vecs[9]  = '{T_LOAD, 0, 4'b0110, 1'b0, 4'b0110, 1'b1, 1};
        vecs[10] = '{T_ROTL, 6, 4'b1111, 1'b1, 4'b1001, 1'b1, 6};
        vecs[11] = '{T_SHL,  3, 4'b0111, 1'b0, 4'b1000, 1'b0, 3};

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_data = '0; ser_in = 1'b0;
`ifdef SHIFT_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_ser_out", 32'(ser_out), 32'd0);
        chk("reset_flags", {29'd0, done, busy, cmd_ready}, 32'b001);
        chk("reset_state", 32'(o_dbg_state), 32'd0);
        m_q = '0;
        m_ser = 1'b0;

        for (int i = 0; i < 12; i++) begin
            fill_sbits(vecs[i].fill);
            run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].exp_q, vecs[i].exp_ser,
                    vecs[i].exp_lat, 1'b0, $sformatf("vec%0d", i));
        end

        // Per-edge trajectories.
        fill_sbits(1'b1);
        run_cmd(T_LOAD, 0, 4'b1100, 4'b1100, m_ser, 1, 1'b0, "traj_load");
        run_cmd(T_SHL, 2, 4'b0000, 4'b0011, 1'b1, 2, 1'b0, "traj_shl");
        chk("traj_shl_e1", 32'(traj[1]), 32'b1001);
        chk("traj_shl_e2", 32'(traj[2]), 32'b0011);
        run_cmd(T_LOAD, 0, 4'b1001, 4'b1001, 1'b1, 1, 1'b0, "traj_load2");
        run_cmd(T_ROTL, 4, 4'b0000, 4'b1001, 1'b1, 4, 1'b0, "traj_rotl");
        chk("traj_rotl_e1", 32'(traj[1]), 32'b0011);
        chk("traj_rotl_e2", 32'(traj[2]), 32'b0110);
        chk("traj_rotl_e3", 32'(traj[3]), 32'b1100);

        // cmd_valid held high while busy must not start a LOAD.
        fill_sbits(1'b0);
        run_cmd(T_SHL, 0, 4'b0000, 4'b1001, 1'b1, 1, 1'b1, "busy_pulse");
        run_cmd(T_SHR, 3, 4'b0000, 4'b0001, 1'b0, 3, 1'b1, "busy_pulse_shr");

        // Reset in the middle of SHR cnt=5.
        fill_sbits(1'b1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = T_SHR; cmd_cnt = 3'd5; cmd_data = 4'b0000;
        @(negedge clk);
        cmd_valid = 1'b0; ser_in = 1'b1;
        @(negedge clk);
        chk("rst_mid_q_e1", 32'(q), 32'b1000);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_q", 32'(q), 32'd0);
        chk("rst_mid_ser_out", 32'(ser_out), 32'd0);
        chk("rst_mid_flags", {29'd0, done, busy, cmd_ready}, 32'b001);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        m_q = '0;
        m_ser = 1'b0;
        run_cmd(T_LOAD, 0, 4'b0101, 4'b0101, 1'b0, 1, 1'b0, "rst_after_load");

`ifdef SHIFT_ABORT_EN
        run_cmd(T_LOAD, 0, 4'b1001, 4'b1001, 1'b0, 1, 1'b0, "abort_load");
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = T_ROTL; cmd_cnt = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_q_e1", 32'(q), 32'b0011);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_q", 32'(q), 32'b0011);
        chk("abort_ser_out", 32'(ser_out), 32'd1);
        @(negedge clk);
        chk("abort_post", {29'd0, done, busy, cmd_ready}, 32'b001);
        m_q = 4'b0011;
        m_ser = 1'b1;
`endif

        // Random commands against the stream model.
        for (int n = 0; n < 40; n++) begin
            rop   = 2'($urandom_range(0, 3));
            rcnt  = $urandom_range(0, 7);
            rdata = W'($urandom_range(0, 15));
            for (int i = 0; i < 64; i++) sbits[i] = 1'($urandom_range(0, 1));
            model(rop, rcnt, rdata, eq, es, lat);
            run_cmd(rop, rcnt, rdata, eq, es, lat, 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
